// File: rtl/regfile_write_sched_pkg.sv
// rtl/regfile_write_sched_pkg.sv - shared sizes, state encoding and requester indices
package regfile_write_sched_pkg;

  localparam int WORD_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_LSU = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  // Round-robin pointer moves to the requester after the one-hot winner
  function automatic logic [1:0] rr_next(input logic [2:0] gnt);
    if (gnt[REQ_ALU]) return REQ_LSU;
    if (gnt[REQ_LSU]) return REQ_DBG;
    return REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_write_sched_if.sv
// rtl/regfile_write_sched_if.sv - writeback requesters, clear control and register-file write port
interface regfile_write_sched_if;

  logic                          ClearReq;
  logic                          Busy;

  logic                          AluReq;
  regfile_write_sched_pkg::addr_t AluAddr;
  regfile_write_sched_pkg::word_t AluData;
  logic                          AluAck;

  logic                          LsuReq;
  regfile_write_sched_pkg::addr_t LsuAddr;
  regfile_write_sched_pkg::word_t LsuData;
  logic                          LsuAck;

  logic                          DbgReq;
  regfile_write_sched_pkg::addr_t DbgAddr;
  regfile_write_sched_pkg::word_t DbgData;
  logic                          DbgAck;

  logic                          WriteFlag;
  regfile_write_sched_pkg::addr_t AddrWrite;
  regfile_write_sched_pkg::word_t Write;

  modport master (
    output ClearReq,
    output AluReq, AluAddr, AluData,
    output LsuReq, LsuAddr, LsuData,
    output DbgReq, DbgAddr, DbgData,
    input  Busy, AluAck, LsuAck, DbgAck,
    input  WriteFlag, AddrWrite, Write
  );

  modport slave (
    input  ClearReq,
    input  AluReq, AluAddr, AluData,
    input  LsuReq, LsuAddr, LsuData,
    input  DbgReq, DbgAddr, DbgData,
    output Busy, AluAck, LsuAck, DbgAck,
    output WriteFlag, AddrWrite, Write
  );

endinterface

// File: rtl/regfile_write_sched_rr_arbiter3.sv
// rtl/regfile_write_sched_rr_arbiter3.sv - combinational 3-way round-robin grant, one-hot output
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      // pointer value 3 is unreachable; treat it like ALU-first
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - register-file write port owner: power-on clear, then round-robin writeback
module regfile_write_sched
  import regfile_write_sched_pkg::*;
(
  input  logic                 gclk,
  input  logic                 PowerOn_n,
  regfile_write_sched_if.slave bus
);

  localparam addr_t CLR_LAST = addr_t'(REG_NUM - 1);

  logic [0:0] state;
  addr_t      clrcnt;
  logic [1:0] rrptr;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [2:0] ack;
  addr_t      win_addr;
  word_t      win_data;
  logic       wflag;
  addr_t      waddr;
  word_t      wdata;

  assign req = {bus.DbgReq, bus.LsuReq, bus.AluReq};

  rr_arbiter3 u_arb (
    .req (req),
    .ptr (rrptr),
    .gnt (gnt)
  );

  // Requesters are locked out entirely while the clear owns the port
  assign ack = (state == ST_RUN) ? gnt : 3'b000;

  assign bus.AluAck    = ack[REQ_ALU];
  assign bus.LsuAck    = ack[REQ_LSU];
  assign bus.DbgAck    = ack[REQ_DBG];
  assign bus.Busy      = (state == ST_CLEAR);
  assign bus.WriteFlag = wflag;
  assign bus.AddrWrite = waddr;
  assign bus.Write     = wdata;

  always_comb begin
    win_addr = bus.AluAddr;
    win_data = bus.AluData;
    if (gnt[REQ_LSU]) begin
      win_addr = bus.LsuAddr;
      win_data = bus.LsuData;
    end else if (gnt[REQ_DBG]) begin
      win_addr = bus.DbgAddr;
      win_data = bus.DbgData;
    end
  end

  always_ff @(posedge gclk or negedge PowerOn_n) begin
    if (!PowerOn_n) begin
      state  <= ST_CLEAR;
      clrcnt <= '0;
      rrptr  <= REQ_ALU;
      wflag  <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (state == ST_CLEAR) begin
      wflag <= 1'b1;
      waddr <= clrcnt;
      wdata <= '0;
      if (clrcnt == CLR_LAST) begin
        state  <= ST_RUN;
        clrcnt <= '0;
      end else begin
        clrcnt <= clrcnt + addr_t'(1);
      end
    end else begin
      wflag <= |ack;
      if (|ack) begin
        waddr <= win_addr;
        wdata <= win_data;
        rrptr <= rr_next(ack);
      end
      // a transfer accepted alongside ClearReq still lands before the first clear write
      if (bus.ClearReq) state <= ST_CLEAR;
    end
  end

endmodule
